seg7_mux_driver: RTL



---
 rtl/seg7_mux_driver_pkg.sv | 16 +
 rtl/seg7_mux_driver_hex_seg_decode.sv | 11 +
 rtl/seg7_mux_driver.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg7_mux_driver_pkg.sv
// Shared constants for the multiplexed 7-segment driver: hex segment table
// (active-high, bit0 = a ... bit6 = g) and pin-polarity helpers.
package seg7_mux_driver_pkg;

  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] seg_pin(input logic [6:0] s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/seg7_mux_driver_hex_seg_decode.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
module hex_seg_decode
  import seg7_mux_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with per-digit enable, decimal
// points, leading-zero suppression, anti-ghost blanking and frame latching.
module seg7_mux_driver
  import seg7_mux_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 4096,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzs,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;

  logic [NUM_DIGITS-1:0][3:0] sh_val, vw_val;
  logic [NUM_DIGITS-1:0]      sh_dp, sh_en, vw_dp, vw_en;
  logic                       sh_lzs, vw_lzs;

  logic latch, slot_end;
  assign latch    = (presc == '0) && (idx == '0);
  assign slot_end = (presc == PW'(REFRESH_DIV - 1));

  // On the latch cycle decode straight from the incoming frame so the first
  // lit slot (even with no blanking) never shows the previous frame.
  always_comb begin
    vw_val = latch ? value    : sh_val;
    vw_dp  = latch ? dp_in    : sh_dp;
    vw_en  = latch ? digit_en : sh_en;
    vw_lzs = latch ? lzs      : sh_lzs;
  end

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:0] upper_zero;
  always_comb begin
    upper_zero = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      for (int j = i; j < NUM_DIGITS; j++)
        if (vw_val[j] != 4'h0) upper_zero[i] = 1'b0;
  end

  logic [6:0] dec_seg;
  hex_seg_decode u_dec (
    .nib (vw_val[idx]),
    .seg (dec_seg)
  );

  logic       blank, supp, lit, dp_on;
  logic [6:0] seg_on;
  always_comb begin
    lit    = 1'b0;
    dp_on  = 1'b0;
    seg_on = SEG_OFF;
    blank  = (presc < PW'(BLANK_CYCLES)) || !vw_en[idx];
    supp   = vw_lzs && (idx != '0) && upper_zero[idx];
    if (!blank) begin
      dp_on = vw_dp[idx];
      // a suppressed digit keeps its anode only to show the decimal point
      if (supp) lit = vw_dp[idx];
      else begin
        lit    = 1'b1;
        seg_on = dec_seg;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc      <= '0;
      idx        <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_lzs     <= 1'b0;
      seg        <= seg_pin(SEG_OFF, SEG_ACTIVE_LOW);
      dp         <= SEG_ACTIVE_LOW;
      an         <= AN_IDLE;
      frame_tick <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (latch) begin
        sh_val <= value;
        sh_dp  <= dp_in;
        sh_en  <= digit_en;
        sh_lzs <= lzs;
      end
      frame_tick <= latch;
      seg        <= seg_pin(seg_on, SEG_ACTIVE_LOW);
      dp         <= dp_on ^ SEG_ACTIVE_LOW;
      an         <= lit ? ((AN_ONE << idx) ^ AN_IDLE) : AN_IDLE;
    end
  end

endmodule
